// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-side memory access unit.
// Holds the access-size encodings, bus FSM state encoding, the bus command
// payload, and lane-formatting helpers that the future dcache will reuse.
package dmem_access_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Access size encodings (2'b11 is reserved and always treated as misaligned)
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } bus_state_e;

  // One bus transaction as presented on the SRAM-like data bus
  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // Byte strobes for a store of the given size at byte offset off
  function automatic logic [STRB_W-1:0] wstrb_gen(input logic [1:0] size,
                                                   input logic [1:0] off);
    logic [STRB_W-1:0] strb;
    strb = '0;
    case (size)
      SZ_B:    strb = STRB_W'(4'b0001 << off);
      SZ_H:    strb = STRB_W'(4'b0011 << off);
      SZ_W:    strb = '1;
      default: strb = '0;
    endcase
    return strb;
  endfunction

  // Replicate right-aligned store data across every lane it could land in
  function automatic logic [DATA_W-1:0] wdata_fmt(input logic [1:0] size,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    case (size)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic m;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      SZ_W:    m = |off;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_access_unit_store_buffer.sv
// In-order posted write buffer (synchronous FIFO of bus commands).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_push, i_data  enqueue one command (caller guarantees not full)
//   i_pop           dequeue head (caller guarantees not empty)
//   o_head          oldest entry, meaningful only when o_empty=0
//   o_full, o_empty occupancy flags
module dmem_access_unit_store_buffer
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  bus_cmd_t i_data,
  input  logic     i_pop,
  output bus_cmd_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);

  bus_cmd_t         r_mem [WB_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage needs no reset: head is only consumed when the buffer is non-empty
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= ptr_inc(r_wptr);
      if (i_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_cnt == CNT_W'(WB_DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/dmem_access_unit.sv
// Data-side memory access unit: alignment check, lane formatting, posted
// write buffer for cached stores, a single pending slot for loads/uncached
// ops, and a one-outstanding bus FSM that keeps bus order = program order.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   req_*                      MEM-stage request (valid/ready handshake)
//   resp_valid/rdata/ale       completion pulse, raw read word, align fault
//   busy                       buffer, pending slot or bus FSM occupied
//   bus_req..bus_wdata         SRAM-like bus command, held until bus_addr_ok
//   bus_addr_ok/data_ok/rdata  bus handshakes and read data
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_paddr,
  input  logic              req_uncached,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_ale,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  bus_state_e r_state;
  bus_state_e w_state_nxt;
  bus_cmd_t   r_cmd;
  bus_cmd_t   r_pend;
  logic       r_pend_vld;
  logic       r_src_pend;
  logic       r_resp_post;
  logic       r_resp_ale;

  bus_cmd_t   w_req_cmd;
  bus_cmd_t   w_head;
  bus_cmd_t   w_issue_cmd;
  logic       w_issue;
  logic       w_issue_pend;
  logic       w_misal;
  logic       w_cached_st;
  logic       w_accept;
  logic       w_push;
  logic       w_accept_pend;
  logic       w_done;
  logic       w_pop;
  logic       w_pend_done;
  logic       w_full;
  logic       w_empty;

  // Request classification and lane formatting
  assign w_misal     = is_misaligned(req_size, req_paddr[1:0]);
  assign w_cached_st = req_we & ~req_uncached;

  always_comb begin
    w_req_cmd       = '0;
    w_req_cmd.wr    = req_we;
    w_req_cmd.size  = req_size;
    w_req_cmd.addr  = req_paddr;
    w_req_cmd.wstrb = req_we ? wstrb_gen(req_size, req_paddr[1:0]) : '0;
    w_req_cmd.wdata = wdata_fmt(req_size, req_wdata);
  end

  // A pending op blocks everything; a full buffer blocks only cached stores
  assign req_ready     = ~r_pend_vld & (w_misal | ~w_cached_st | ~w_full);
  assign w_accept      = req_valid & req_ready;
  assign w_push        = w_accept & ~w_misal & w_cached_st;
  assign w_accept_pend = w_accept & ~w_misal & ~w_cached_st;

  assign w_done      = (r_state == ST_DATA) & bus_data_ok;
  assign w_pop       = w_done & ~r_src_pend;
  assign w_pend_done = w_done & r_src_pend;

  dmem_access_unit_store_buffer #(
    .WB_DEPTH (WB_DEPTH)
  ) u_store_buffer (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_req_cmd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Bus FSM next state; an op accepted while idle issues at the accept edge
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_pend = 1'b0;
    w_issue_cmd  = w_head;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_issue     = 1'b1;
          w_issue_cmd = w_head;
        end else if (w_push) begin
          w_issue     = 1'b1;
          w_issue_cmd = w_req_cmd;
        end else if (r_pend_vld) begin
          w_issue      = 1'b1;
          w_issue_pend = 1'b1;
          w_issue_cmd  = r_pend;
        end else if (w_accept_pend) begin
          w_issue      = 1'b1;
          w_issue_pend = 1'b1;
          w_issue_cmd  = w_req_cmd;
        end
        if (w_issue) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: if (bus_addr_ok) w_state_nxt = ST_DATA;
      ST_DATA: if (bus_data_ok) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Bus command is latched only on issue, so it stays stable while bus_req=1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd      <= '0;
      r_src_pend <= 1'b0;
    end else if (w_issue) begin
      r_cmd      <= w_issue_cmd;
      r_src_pend <= w_issue_pend;
    end
  end

  // Pending slot for loads and uncached ops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
    end else if (w_accept_pend) begin
      r_pend_vld <= 1'b1;
      r_pend     <= w_req_cmd;
    end else if (w_pend_done) begin
      r_pend_vld <= 1'b0;
    end
  end

  // Posted stores and misaligned requests complete the cycle after accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_post <= 1'b0;
      r_resp_ale  <= 1'b0;
    end else begin
      r_resp_post <= w_accept & (w_misal | w_cached_st);
      r_resp_ale  <= w_accept & w_misal;
    end
  end

  assign resp_valid = r_resp_post | w_pend_done;
  assign resp_ale   = r_resp_ale;
  assign resp_rdata = (w_pend_done & ~r_cmd.wr) ? bus_rdata : '0;
  assign busy       = ~w_empty | r_pend_vld | (r_state != ST_IDLE);

  assign bus_req   = (r_state == ST_ADDR);
  assign bus_wr    = r_cmd.wr;
  assign bus_size  = r_cmd.size;
  assign bus_addr  = r_cmd.addr;
  assign bus_wstrb = r_cmd.wstrb;
  assign bus_wdata = r_cmd.wdata;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized self-checking bench for dmem_access_unit with a
// transaction-level reference model (program-order queues) and directed cases.
module tb_dmem_access_unit;

  localparam int unsigned WB_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_uncached;
  logic [1:0]  req_size;
  logic [31:0] req_paddr, req_wdata;
  logic        resp_valid, resp_ale, busy;
  logic [31:0] resp_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  dmem_access_unit #(.WB_DEPTH(WB_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_paddr(req_paddr), .req_uncached(req_uncached),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_ale(resp_ale),
    .busy(busy),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle)", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit pend; bit load; bit ale; int due; } resp_t;
  typedef struct { bit wr; bit [1:0] size; bit [31:0] addr; bit [3:0] strb; bit [31:0] wdata; bit pend; } bcmd_t;

  resp_t resp_q[$];
  bcmd_t bus_q[$];
  int    buf_cnt = 0;
  bit    pend_out = 0, in_data = 0, cur_pend = 0, cur_cached = 0, prev_hold = 0;
  logic [70:0] prev_snap;

  // stimulus controls
  bit        s_valid = 0, s_we = 0, s_unc = 0, rand_req = 0, rd_fixed = 1;
  bit [1:0]  s_size = 0;
  bit [31:0] s_addr = 0, s_wdata = 0, rd_val = 0;
  int        aok_mode = 1, dok_mode = 1;

  // observations
  int  cyc = 0, acc_cyc = 0, resp_cyc = 0, dok_cyc = 0;
  bit  acc_flag = 0;
  logic [31:0] last_rdata;
  logic        last_ale;
  bit [31:0] log_addr[$], log_wdata[$];
  bit [3:0]  log_strb[$];
  bit        log_wr[$];

  function automatic bit misal_f(input bit [1:0] sz, input bit [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic bit [3:0] strb_f(input bit [1:0] sz, input bit [31:0] a, input bit we);
    bit [3:0] s;
    int nb, off;
    s = 4'd0;
    nb = 1 << sz;
    off = int'(a % 4);
    for (int lane = 0; lane < 4; lane++)
      s[lane] = we && (lane >= off) && (lane < off + nb);
    return s;
  endfunction

  function automatic bit [31:0] wdata_f(input bit [1:0] sz, input bit [31:0] d);
    if (sz == 2'd0) return 32'(d[7:0]) * 32'h0101_0101;
    if (sz == 2'd1) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  // One clock: drive at posedge+1, sample and update model at posedge+2
  task automatic step();
    bit dok_hs, addr_hs, pend_done, posted_due, exp_resp, exp_ready, is_cst;
    logic [70:0] snap;
    resp_t r;
    bcmd_t c;
    bit [31:0] base;
    @(posedge clk); #1;
    cyc++;
    if (rand_req) begin
      s_valid = ($urandom % 10) < 7;
      s_we    = 1'($urandom % 2);
      s_unc   = ($urandom % 4) == 0;
      s_size  = 2'($urandom_range(0, 3));
      case ($urandom % 3)
        0: base = 32'h0000_0100;
        1: base = 32'h1C00_0000;
        default: base = 32'hBFD0_0000;
      endcase
      s_addr  = base + $urandom_range(0, 15);
      s_wdata = $urandom;
    end
    req_valid = s_valid; req_we = s_we; req_uncached = s_unc;
    req_size = s_size; req_paddr = s_addr; req_wdata = s_wdata;
    bus_addr_ok = (aok_mode == 0) ? 1'($urandom % 2) : (aok_mode == 1);
    case (dok_mode)
      0: bus_data_ok = in_data & 1'($urandom % 2);
      1: bus_data_ok = in_data;
      2: bus_data_ok = 1'b0;
      default: bus_data_ok = 1'b1;
    endcase
    bus_rdata = rd_fixed ? rd_val : $urandom;
    #1;
    is_cst = s_we && !s_unc;
    exp_ready = !pend_out && (misal_f(s_size, s_addr) || !is_cst || buf_cnt < WB_DEPTH);
    if (s_valid) check_eq("req_ready", req_ready, exp_ready);
    dok_hs = in_data && bus_data_ok;
    pend_done = dok_hs && cur_pend;
    posted_due = resp_q.size() > 0 && !resp_q[0].pend && resp_q[0].due == cyc;
    exp_resp = pend_done || posted_due;
    check_eq("resp_valid", resp_valid, exp_resp);
    if (exp_resp && resp_q.size() > 0) begin
      r = resp_q.pop_front();
      if (resp_valid) begin
        check_eq("resp_ale", resp_ale, r.ale);
        check_eq("resp_rdata", resp_rdata, r.load ? bus_rdata : 32'd0);
        resp_cyc = cyc; last_rdata = resp_rdata; last_ale = resp_ale;
      end
    end
    if (in_data) check_eq("bus_req_in_data", bus_req, 1'b0);
    snap = {bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata};
    if (prev_hold) begin
      check_eq("bus_req_held", bus_req, 1'b1);
      check_eq("bus_cmd_stable", snap, prev_snap);
    end
    addr_hs = bus_req && bus_addr_ok;
    if (addr_hs) begin
      check_eq("bus_req_expected", bus_q.size() > 0, 1'b1);
      if (bus_q.size() > 0) begin
        c = bus_q.pop_front();
        check_eq("bus_addr", bus_addr, c.addr);
        check_eq("bus_wr", bus_wr, c.wr);
        check_eq("bus_size", bus_size, c.size);
        check_eq("bus_wstrb", bus_wstrb, c.strb);
        if (c.wr) check_eq("bus_wdata", bus_wdata, c.wdata);
        cur_pend = c.pend; cur_cached = !c.pend;
      end
      log_addr.push_back(bus_addr); log_wdata.push_back(bus_wdata);
      log_strb.push_back(bus_wstrb); log_wr.push_back(bus_wr);
    end
    prev_hold = bus_req && !bus_addr_ok;
    prev_snap = snap;
    if (dok_hs) begin
      dok_cyc = cyc;
      if (cur_cached) buf_cnt--;
      if (cur_pend) pend_out = 0;
    end
    acc_flag = req_valid && req_ready;
    if (acc_flag) begin
      acc_cyc = cyc;
      c = '{wr: s_we, size: s_size, addr: s_addr, strb: strb_f(s_size, s_addr, s_we),
            wdata: wdata_f(s_size, s_wdata), pend: 1'b0};
      if (misal_f(s_size, s_addr)) begin
        resp_q.push_back('{pend: 1'b0, load: 1'b0, ale: 1'b1, due: cyc + 1});
      end else if (is_cst) begin
        buf_cnt++;
        bus_q.push_back(c);
        resp_q.push_back('{pend: 1'b0, load: 1'b0, ale: 1'b0, due: cyc + 1});
      end else begin
        pend_out = 1;
        c.pend = 1'b1;
        bus_q.push_back(c);
        resp_q.push_back('{pend: 1'b1, load: !s_we, ale: 1'b0, due: 0});
      end
    end
    in_data = (in_data && !dok_hs) || addr_hs;
  endtask

  task automatic issue(input string tag, input bit we, input bit [1:0] sz,
                       input bit [31:0] a, input bit unc, input bit [31:0] d);
    s_we = we; s_size = sz; s_addr = a; s_unc = unc; s_wdata = d; s_valid = 1;
    acc_flag = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (acc_flag) break;
    end
    check_eq({"accept_", tag}, acc_flag, 1'b1);
    s_valid = 0;
  endtask

  task automatic drain(input string tag);
    s_valid = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (!busy && resp_q.size() == 0 && bus_q.size() == 0) break;
    end
    check_eq({"drain_busy_", tag}, busy, 1'b0);
    check_eq({"drain_resp_", tag}, resp_q.size(), 0);
    check_eq({"drain_bus_", tag}, bus_q.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_req_ready"}, req_ready, 1'b1);
    check_eq({tag, "_resp_valid"}, resp_valid, 1'b0);
    check_eq({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check_eq({tag, "_resp_ale"}, resp_ale, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_bus_req"}, bus_req, 1'b0);
    check_eq({tag, "_bus_cmd"}, {bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata}, 71'd0);
  endtask

  int base_i, t_acc;

  initial begin
    reset = 1'b0;
    req_valid = 0; req_we = 0; req_size = 0; req_paddr = 0; req_uncached = 0; req_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    #12;
    check_reset_outs("por");
    #10 reset = 1'b1;

    // Word load, immediate addr_ok, data_ok one cycle later
    aok_mode = 1; dok_mode = 1; rd_fixed = 1; rd_val = 32'hDEADBEEF;
    issue("t1_load", 1'b0, 2'd2, 32'h1C00_0004, 1'b0, 32'd0);
    t_acc = acc_cyc;
    drain("t1");
    check_eq("t1_latency", resp_cyc - t_acc, 2);
    check_eq("t1_rdata", last_rdata, 32'hDEADBEEF);
    check_eq("t1_ale", last_ale, 1'b0);

    // Three byte stores against a stalled bus fill the buffer
    aok_mode = 2; base_i = log_addr.size();
    issue("t2_st0", 1'b1, 2'd0, 32'h100, 1'b0, 32'hAB);
    issue("t2_st1", 1'b1, 2'd0, 32'h101, 1'b0, 32'hAB);
    s_we = 1; s_size = 0; s_addr = 32'h102; s_unc = 0; s_wdata = 32'hAB; s_valid = 1;
    repeat (4) step();
    check_eq("t2_full_stall", req_ready, 1'b0);
    aok_mode = 1;
    issue("t2_st2", 1'b1, 2'd0, 32'h102, 1'b0, 32'hAB);
    drain("t2");
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_addr", log_addr[base_i + i], 32'h100 + i);
      check_eq("t2_wstrb", log_strb[base_i + i], 4'b0001 << i);
      check_eq("t2_wdata", log_wdata[base_i + i], 32'hABABABAB);
    end

    // Cached store then uncached load: bus order follows program order
    dok_mode = 0; rd_fixed = 0; base_i = log_addr.size();
    issue("t3_st", 1'b1, 2'd2, 32'h200, 1'b0, 32'h11223344);
    issue("t3_ld", 1'b0, 2'd2, 32'hBFD0_0000, 1'b1, 32'd0);
    drain("t3");
    check_eq("t3_first_addr", log_addr[base_i], 32'h200);
    check_eq("t3_first_wr", log_wr[base_i], 1'b1);
    check_eq("t3_second_addr", log_addr[base_i + 1], 32'hBFD0_0000);
    check_eq("t3_second_wr", log_wr[base_i + 1], 1'b0);
    check_eq("t3_resp_on_dok", resp_cyc, dok_cyc);

    // Misaligned half load and reserved size never reach the bus
    base_i = log_addr.size();
    issue("t4_half", 1'b0, 2'd1, 32'h203, 1'b0, 32'd0);
    t_acc = acc_cyc;
    drain("t4a");
    check_eq("t4_half_lat", resp_cyc - t_acc, 1);
    check_eq("t4_half_ale", last_ale, 1'b1);
    issue("t4_rsv", 1'b1, 2'd3, 32'h200, 1'b0, 32'h55);
    drain("t4b");
    check_eq("t4_rsv_ale", last_ale, 1'b1);
    check_eq("t4_no_bus", log_addr.size(), base_i);

    // Uncached word store completes with the bus data_ok
    base_i = log_addr.size();
    issue("t5_ust", 1'b1, 2'd2, 32'h1FE0_01E0, 1'b1, 32'h12345678);
    drain("t5");
    check_eq("t5_wr", log_wr[base_i], 1'b1);
    check_eq("t5_wstrb", log_strb[base_i], 4'hF);
    check_eq("t5_wdata", log_wdata[base_i], 32'h12345678);
    check_eq("t5_resp_on_dok", resp_cyc, dok_cyc);

    // Reset while a buffered store sits in the data phase
    aok_mode = 1; dok_mode = 2;
    issue("t6_st", 1'b1, 2'd2, 32'h300, 1'b0, 32'hCAFE);
    for (int i = 0; i < 20 && !in_data; i++) step();
    check_eq("t6_in_data", in_data, 1'b1);
    check_eq("t6_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outs("mid");
    resp_q.delete(); bus_q.delete();
    buf_cnt = 0; pend_out = 0; in_data = 0; prev_hold = 0; cur_pend = 0; cur_cached = 0;
    #1 reset = 1'b1;
    dok_mode = 3;
    step();
    check_eq("t6_stray_resp", resp_valid, 1'b0);
    dok_mode = 0;
    step();
    check_eq("t6_idle_busy", busy, 1'b0);

    // Random traffic against random bus latencies
    rand_req = 1; aok_mode = 0; dok_mode = 0; rd_fixed = 0;
    repeat (3000) step();
    rand_req = 0;
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
